// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Qualifies the synchronized PLL lock, then releases the reset domains one
//   at a time (bit 0 first, bit STAGES-1 = core last). Lock loss, an attack
//   alarm or a software request puts every domain back into reset. The cause
//   of the last reset and a saturating count of non-POR resets stay readable.
//
// Ports
//   clk           system clock (PLL output domain)
//   reset_n       synchronous active-low reset, overrides everything
//   pll_locked    PLL lock, already synchronized to clk
//   sw_reset_req  software reset request, single-cycle pulse
//   attack_alarm  attack-monitor flags, any bit high = alarm
//   domain_reset  per-domain reset, 1 = held in reset
//   ready         all domains released
//   reset_cause   0 POR, 1 SW, 2 LOCK_LOST, 3 ALARM
//   reset_events  saturating count of non-POR reset events
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_WAIT    | all domains in reset, counting consecutive locked cycles
// ST_RELEASE | releasing domains one per STAGE_GAP cycles
// ST_RUN     | all domains released, watching for abort events
// ST_HOLD    | all domains in reset for HOLD_CYCLES after a sw/alarm reset

module reset_sequencer #(
  parameter int LOCK_CYCLES = 16,
  parameter int STAGES      = 3,
  parameter int STAGE_GAP   = 8,
  parameter int HOLD_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              sw_reset_req,
  input  logic [1:0]        attack_alarm,
  output logic [STAGES-1:0] domain_reset,
  output logic              ready,
  output logic [1:0]        reset_cause,
  output logic [7:0]        reset_events
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1)   ? $clog2(STAGE_GAP)   : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  // Mask after the first (bit 0) release; all zero when there is one domain.
  localparam logic [STAGES-1:0] FIRST_MASK = {STAGES{1'b1}} << 1;

  localparam logic [1:0] CAUSE_POR   = 2'd0;
  localparam logic [1:0] CAUSE_SW    = 2'd1;
  localparam logic [1:0] CAUSE_LOCK  = 2'd2;
  localparam logic [1:0] CAUSE_ALARM = 2'd3;

  typedef enum logic [1:0] {ST_WAIT, ST_RELEASE, ST_RUN, ST_HOLD} state_t;

  state_t            state;
  logic [LOCK_W-1:0] lock_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  // Released bits are always the low-order ones, so shifting the mask left
  // by one clears exactly the next domain in order.
  logic [STAGES-1:0] next_mask;
  logic [7:0]        events_next;
  logic              abort;

  assign next_mask   = domain_reset << 1;
  assign events_next = (reset_events == 8'hFF) ? reset_events : reset_events + 8'd1;
  assign abort       = !pll_locked || (|attack_alarm) || sw_reset_req;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_WAIT;
      lock_cnt     <= '0;
      gap_cnt      <= '0;
      hold_cnt     <= '0;
      domain_reset <= '1;
      ready        <= 1'b0;
      reset_cause  <= CAUSE_POR;
      reset_events <= 8'd0;
    end else begin
      case (state)
        ST_WAIT: begin
          domain_reset <= '1;
          ready        <= 1'b0;
          if (!pll_locked) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            lock_cnt     <= '0;
            gap_cnt      <= '0;
            domain_reset <= FIRST_MASK;
            if (STAGES == 1) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        ST_RELEASE, ST_RUN: begin
          if (abort) begin
            // Priority: lock loss, then alarm, then software request.
            domain_reset <= '1;
            ready        <= 1'b0;
            reset_events <= events_next;
            if (!pll_locked) begin
              reset_cause <= CAUSE_LOCK;
              lock_cnt    <= '0;
              state       <= ST_WAIT;
            end else begin
              reset_cause <= (|attack_alarm) ? CAUSE_ALARM : CAUSE_SW;
              hold_cnt    <= '0;
              state       <= ST_HOLD;
            end
          end else if (state == ST_RELEASE) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt      <= '0;
              domain_reset <= next_mask;
              if (next_mask == '0) begin
                state <= ST_RUN;
                ready <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        ST_HOLD: begin
          domain_reset <= '1;
          ready        <= 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            lock_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios plus a randomized phase,
// every cycle compared against a time-based reference model.

module tb_reset_sequencer;

  localparam int LOCK_CYCLES = 16;
  localparam int STAGES      = 3;
  localparam int STAGE_GAP   = 8;
  localparam int HOLD_CYCLES = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              pll_locked;
  logic              sw_reset_req;
  logic [1:0]        attack_alarm;
  logic [STAGES-1:0] domain_reset;
  logic              ready;
  logic [1:0]        reset_cause;
  logic [7:0]        reset_events;

  int errors = 0;
  int checks = 0;

  // Reference model: m_run = consecutive locked samples while waiting,
  // m_age = edges since release began (-1 when not released),
  // m_hold = edges of hold still to go.
  int m_run    = 0;
  int m_age    = -1;
  int m_hold   = 0;
  int m_cause  = 0;
  int m_events = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .LOCK_CYCLES (LOCK_CYCLES),
    .STAGES      (STAGES),
    .STAGE_GAP   (STAGE_GAP),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .sw_reset_req (sw_reset_req),
    .attack_alarm (attack_alarm),
    .domain_reset (domain_reset),
    .ready        (ready),
    .reset_cause  (reset_cause),
    .reset_events (reset_events)
  );

  function automatic logic [STAGES-1:0] exp_domain();
    logic [STAGES-1:0] d;
    for (int i = 0; i < STAGES; i++) d[i] = !(m_age >= i * STAGE_GAP);
    return d;
  endfunction

  function automatic logic exp_ready();
    return (m_age >= (STAGES - 1) * STAGE_GAP);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rn, input logic lk, input logic sw, input logic [1:0] al);
    if (!rn) begin
      m_run = 0; m_age = -1; m_hold = 0; m_cause = 0; m_events = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_age >= 0) begin
      if (!lk || al != 2'b00 || sw) begin
        if (m_events < 255) m_events++;
        m_age = -1;
        m_run = 0;
        if (!lk) m_cause = 2;
        else begin
          m_hold  = HOLD_CYCLES;
          m_cause = (al != 2'b00) ? 3 : 1;
        end
      end else begin
        m_age++;
      end
    end else begin
      if (lk) begin
        m_run++;
        if (m_run == LOCK_CYCLES) begin
          m_run = 0;
          m_age = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic rn, input logic lk, input logic sw, input logic [1:0] al);
    reset_n      = rn;
    pll_locked   = lk;
    sw_reset_req = sw;
    attack_alarm = al;
    @(posedge clk);
    model_edge(rn, lk, sw, al);
    #1;
    chk("model domain_reset", 32'(domain_reset), 32'(exp_domain()));
    chk("model ready",        32'(ready),        32'(exp_ready()));
    chk("model reset_cause",  32'(reset_cause),  32'(m_cause));
    chk("model reset_events", 32'(reset_events), 32'(m_events));
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 2'b00);
  endtask

  initial begin
    int g;
    reset_n = 1'b0; pll_locked = 1'b1; sw_reset_req = 1'b0; attack_alarm = 2'b00;

    // Power-on reset
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 2'b00);
    chk("por domain", 32'(domain_reset), 32'h7);
    chk("por ready",  32'(ready), 32'h0);
    chk("por cause",  32'(reset_cause), 32'h0);
    chk("por events", 32'(reset_events), 32'h0);

    // Staged release after POR
    for (int k = 1; k <= 32; k++) begin
      idle();
      if (k == 15) chk("por k15 domain", 32'(domain_reset), 32'h7);
      if (k == 16) chk("por k16 domain", 32'(domain_reset), 32'h6);
      if (k == 23) chk("por k23 domain", 32'(domain_reset), 32'h6);
      if (k == 24) chk("por k24 domain", 32'(domain_reset), 32'h4);
      if (k == 31) chk("por k31 ready",  32'(ready), 32'h0);
      if (k == 32) begin
        chk("por k32 domain", 32'(domain_reset), 32'h0);
        chk("por k32 ready",  32'(ready), 32'h1);
        chk("por k32 cause",  32'(reset_cause), 32'h0);
      end
    end
    for (int k = 0; k < 5; k++) idle();

    // Lock loss in RUN
    step(1'b1, 1'b0, 1'b0, 2'b00);
    chk("lockloss domain", 32'(domain_reset), 32'h7);
    chk("lockloss ready",  32'(ready), 32'h0);
    chk("lockloss cause",  32'(reset_cause), 32'h2);
    chk("lockloss events", 32'(reset_events), 32'h1);
    for (int k = 1; k <= 32; k++) begin
      idle();
      if (k == 16) chk("relock k16 domain", 32'(domain_reset), 32'h6);
      if (k == 32) chk("relock k32 ready",  32'(ready), 32'h1);
    end

    // Lock glitch while waiting
    step(1'b1, 1'b0, 1'b0, 2'b00);
    chk("lockloss2 events", 32'(reset_events), 32'h2);
    for (int k = 0; k < 10; k++) idle();
    step(1'b1, 1'b0, 1'b0, 2'b00);
    for (int k = 1; k <= 32; k++) begin
      idle();
      if (k == 15) chk("glitch k15 domain", 32'(domain_reset), 32'h7);
      if (k == 16) chk("glitch k16 domain", 32'(domain_reset), 32'h6);
      if (k == 32) chk("glitch k32 ready",  32'(ready), 32'h1);
    end

    // Software reset in RUN
    step(1'b1, 1'b1, 1'b1, 2'b00);
    chk("sw domain", 32'(domain_reset), 32'h7);
    chk("sw cause",  32'(reset_cause), 32'h1);
    chk("sw events", 32'(reset_events), 32'h3);
    for (int k = 1; k <= 64; k++) begin
      idle();
      if (k == 32) chk("sw k32 domain", 32'(domain_reset), 32'h7);
      if (k == 47) chk("sw k47 domain", 32'(domain_reset), 32'h7);
      if (k == 48) chk("sw k48 domain", 32'(domain_reset), 32'h6);
      if (k == 63) chk("sw k63 ready",  32'(ready), 32'h0);
      if (k == 64) chk("sw k64 ready",  32'(ready), 32'h1);
    end

    // Simultaneous sw request and alarm during RELEASE
    step(1'b1, 1'b1, 1'b1, 2'b00);
    for (int k = 0; k < 48 + 3; k++) idle();
    chk("pre-simul domain", 32'(domain_reset), 32'h6);
    step(1'b1, 1'b1, 1'b1, 2'b01);
    chk("simul domain", 32'(domain_reset), 32'h7);
    chk("simul cause",  32'(reset_cause), 32'h3);
    chk("simul events", 32'(reset_events), 32'h5);
    for (int k = 0; k < 40; k++) idle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic rn, lk, sw;
      logic [1:0] al;
      rn = ($urandom_range(0, 399) != 0);
      lk = ($urandom_range(0, 79) != 0);
      sw = ($urandom_range(0, 49) == 0);
      al = ($urandom_range(0, 99) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(rn, lk, sw, al);
    end

    // Saturation of the event counter
    for (int r = 0; r < 260; r++) begin
      g = 0;
      while (domain_reset[0] !== 1'b0 && g < 200) begin
        idle();
        g++;
      end
      checks++;
      assert (g < 200)
      else begin
        errors++;
        $error("FAIL sat wait: observed=%0d cycles expected=<200", g);
      end
      step(1'b1, 1'b1, 1'b1, 2'b00);
    end
    chk("sat events", 32'(reset_events), 32'hFF);
    chk("sat cause",  32'(reset_cause), 32'h1);

    // reset_n low in the middle of RELEASE
    g = 0;
    while (domain_reset !== 3'b110 && g < 200) begin
      idle();
      g++;
    end
    chk("midrel reached", 32'(domain_reset), 32'h6);
    idle();
    idle();
    step(1'b0, 1'b1, 1'b0, 2'b00);
    chk("midrel domain", 32'(domain_reset), 32'h7);
    chk("midrel ready",  32'(ready), 32'h0);
    chk("midrel cause",  32'(reset_cause), 32'h0);
    chk("midrel events", 32'(reset_events), 32'h0);
    for (int k = 0; k < 20; k++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
